// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS bit
// positions and the TX/RX state encodings.
package uart_pkg;

    // Register offsets inside the peripheral window
    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_DATA   = 1'b1;

    // STATUS / CTRL bit positions
    localparam int unsigned STAT_RX_AVAIL  = 0;
    localparam int unsigned STAT_TX_FULL   = 1;
    localparam int unsigned STAT_OVERRUN   = 2;
    localparam int unsigned STAT_FRAME_ERR = 3;
    localparam int unsigned STAT_TX_IDLE   = 4;
    localparam int unsigned STAT_IE_RX     = 5;
    localparam int unsigned STAT_IE_TX     = 6;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead output. A pop is applied before a push in
// the same cycle, so a full FIFO can accept a push when it is also popped.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    // Pointer update; contents are discarded by reset via the pointers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage write
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_slave.sv
// Memory-mapped 8N1 UART with RX/TX FIFOs, level interrupt and a line-break
// reset request used to force the system back into its loader.
module uart_slave
    import uart_pkg::*;
#(
    parameter int unsigned SYS_FREQ   = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BREAK_BITS = 20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_addr,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_cs,
    input  logic       i_we,
    output logic       o_ack,
    output logic       o_int,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_reset
);

    localparam int unsigned CLKS_PER_BIT = SYS_FREQ / BAUD;
    localparam int unsigned BREAK_CYCLES = BREAK_BITS * CLKS_PER_BIT;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW           = $clog2(BREAK_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BREAK_MAX  = BW'(BREAK_CYCLES);

    // Bus side
    logic       ack_q, int_q, ie_rx_q, ie_tx_q, overrun_q, frame_err_q;
    logic [7:0] dat_q, status, rd_data;
    logic       accept, rd_en, ctrl_wr, tx_push, rx_pop;

    // FIFOs
    logic [7:0] tx_dout, rx_dout;
    logic       tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;

    // TX shifter
    tx_state_e  tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_line_q, tx_line_d;
    logic       tx_idle;

    // RX sampler and break detector
    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e  rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       frame_err_set, overrun_set;
    logic [BW-1:0] brk_cnt_q, brk_cnt_d;

    assign accept  = i_cs & ~ack_q;
    assign rd_en   = accept & ~i_we;
    assign ctrl_wr = accept & i_we & (i_addr == ADDR_STATUS);
    assign tx_push = accept & i_we & (i_addr == ADDR_DATA);
    assign rx_pop  = rd_en & (i_addr == ADDR_DATA) & ~rx_empty;

    assign tx_idle     = (tx_state_q == TxIdle) & tx_empty;
    // A push into a full FIFO only survives if the bus pops in the same cycle
    assign overrun_set = rx_push & rx_full & ~rx_pop;

    assign o_ack   = ack_q;
    assign o_dat   = dat_q;
    assign o_int   = int_q;
    assign o_tx    = tx_line_q;
    assign o_reset = (brk_cnt_q == BREAK_MAX) & ~rx_sync_q;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (i_dat),
        .dout   (tx_dout),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .push   (rx_push),
        .pop    (rx_pop),
        .din    (rx_shift_q),
        .dout   (rx_dout),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    // STATUS word and read-data mux
    always_comb begin
        status                 = '0;
        status[STAT_RX_AVAIL]  = ~rx_empty;
        status[STAT_TX_FULL]   = tx_full;
        status[STAT_OVERRUN]   = overrun_q;
        status[STAT_FRAME_ERR] = frame_err_q;
        status[STAT_TX_IDLE]   = tx_idle;
        status[STAT_IE_RX]     = ie_rx_q;
        status[STAT_IE_TX]     = ie_tx_q;
        if (i_addr == ADDR_DATA) begin
            rd_data = rx_empty ? 8'h00 : rx_dout;
        end else begin
            rd_data = status;
        end
    end

    // Bus registers: ack, read data, enables, sticky flags (set beats clear), interrupt
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ack_q       <= 1'b0;
            dat_q       <= 8'h00;
            ie_rx_q     <= 1'b0;
            ie_tx_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            ack_q <= accept;
            if (rd_en) dat_q <= rd_data;
            if (ctrl_wr) begin
                ie_rx_q <= i_dat[STAT_IE_RX];
                ie_tx_q <= i_dat[STAT_IE_TX];
            end
            overrun_q   <= overrun_set |
                           (overrun_q & ~(ctrl_wr & i_dat[STAT_OVERRUN]));
            frame_err_q <= frame_err_set |
                           (frame_err_q & ~(ctrl_wr & i_dat[STAT_FRAME_ERR]));
            int_q       <= (ie_rx_q & ~rx_empty) | (ie_tx_q & tx_idle);
        end
    end

    // TX next-state: bit timing, FIFO pop on leaving IDLE or chaining from STOP
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TxIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_dout;
                    tx_cnt_d   = '0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxData: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxStop: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit: no idle gap
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_dout;
                        tx_state_d = TxStart;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
        case (tx_state_d)
            TxStart: tx_line_d = 1'b0;
            TxData:  tx_line_d = tx_shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    // TX state register; line output is registered and idles high
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // RX next-state: start-bit recheck at half bit, then sample at bit centres
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_push       = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // Glitch shorter than half a bit: abandon the frame
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxData: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxStop: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d      = '0;
                    rx_state_d    = RxIdle;
                    rx_push       = rx_sync_q;
                    frame_err_set = ~rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RxIdle;
        endcase
        if (rx_sync_q) begin
            brk_cnt_d = '0;
        end else if (brk_cnt_q == BREAK_MAX) begin
            brk_cnt_d = brk_cnt_q;
        end else begin
            brk_cnt_d = brk_cnt_q + BW'(1);
        end
    end

    // RX synchronizer, state register and saturating break counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            brk_cnt_q  <= '0;
        end else begin
            rx_meta_q  <= i_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            brk_cnt_q  <= brk_cnt_d;
        end
    end

endmodule

// File: doc/uart_slave.md
# uart_slave

Memory-mapped UART peripheral occupying the 0xfa00–0xfa0f window of the system bus: the bus slave behind the UART chip-select, clocked on the system clock. Converts single-byte bus reads/writes into 8N1 serial frames with RX and TX FIFOs, a level interrupt, and a break-triggered reset request. The request lets a host force the system back to its loader.

## Interface
- SYS_FREQ, 25000000: system clock frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = SYS_FREQ/BAUD, integer division, must be ≥ 4.
- FIFO_DEPTH, 16: entries per FIFO, power of two, ≥ 2.
- BREAK_BITS, 20: RX-low duration in bit times that constitutes a break.
- Clock and reset: one clock, i_clk. Reset i_reset is asynchronous and active-high.
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-high reset
- i_addr  in  1  register select: 0 = STATUS/CTRL, 1 = DATA
- i_dat  in  8  write data
- o_dat  out  8  read data, registered
- i_cs  in  1  chip select
- i_we  in  1  1 = write, 0 = read
- o_ack  out  1  one-cycle access acknowledge
- o_int  out  1  level interrupt
- i_rx  in  1  serial input, asynchronous
- o_tx  out  1  serial output, idle high
- o_reset  out  1  system reset request on line break

## Operation
- Reset values:
  - o_tx = 1; o_dat = 0x00; o_ack = 0; o_int = 0; o_reset = 0.
  - Both FIFOs empty; all flags 0; both interrupt enables 0.
- Bus access:
  - Accepted on any cycle with i_cs = 1 and o_ack = 0.
  - o_ack = 1 on the following cycle, exactly one cycle.
  - If i_cs is still high after the ack cycle, that is a new access.
- STATUS read (addr 0), bit layout:
  - [0] rx_avail (RX FIFO not empty)
  - [1] tx_full
  - [2] rx_overrun
  - [3] rx_frame_err
  - [4] tx_idle (TX FIFO empty and shifter idle)
  - [5] ie_rx
  - [6] ie_tx
  - [7] 0
- CTRL write (addr 0):
  - Bits [5] and [6] load ie_rx and ie_tx.
  - Writing 1 to [2] clears rx_overrun; writing 1 to [3] clears rx_frame_err.
  - If a flag-set event and a clear occur in the same cycle, set wins.
- DATA read (addr 1): returns the RX FIFO head and pops it. On an empty FIFO, returns 0x00 with no state change.
- DATA write (addr 1): pushes to the TX FIFO. On a full FIFO, the byte is silently dropped.
- o_int = (ie_rx & rx_avail) | (ie_tx & tx_idle), registered.
- TX state machine: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - Each state lasts CLKS_PER_BIT cycles.
  - The TX FIFO is popped when leaving IDLE.
  - Back-to-back bytes produce no idle gap.
- RX path:
  - i_rx passes through a 2-flop synchronizer.
  - RX state machine: IDLE → START → DATA → STOP.
  - A falling edge starts a frame. The start bit is re-checked low at CLKS_PER_BIT/2; if high, the frame is aborted to IDLE.
  - Data bits are sampled at bit centres.
  - Stop bit low: byte discarded and rx_frame_err set.
  - Stop bit high: byte pushed. If the RX FIFO is full, the byte is dropped and rx_overrun set, unless a bus pop happens the same cycle, in which case the push succeeds.
- Break detection:
  - A counter of consecutive synchronized-low cycles is kept.
  - When it reaches BREAK_BITS·CLKS_PER_BIT, o_reset = 1.
  - o_reset stays high until the first synchronized-high sample. The counter saturates.
  - A frame aborted by a break is not pushed.

## Timing
- Read data: o_dat is valid in the o_ack cycle, i.e. one cycle after acceptance.
- Effect of writes:
  - A FIFO push or flag update is visible to a STATUS read accepted the cycle after o_ack.
  - A TX write with the shifter idle drives the start bit 2 cycles after acceptance.
- RX latency: rx_avail rises 3 cycles after the stop-bit centre sample (2 synchronizer + 1 push).
- Reset mid-frame: o_tx returns high immediately (asynchronous) and FIFO contents are lost.

## Structure
- Package uart_pkg holds:
  - Register offsets ADDR_STATUS / ADDR_DATA.
  - STATUS bit indices.
  - TX and RX state encodings.
- Sub-module uart_fifo is instantiated twice.
  - Parameters: WIDTH and DEPTH.
  - Ports: push/pop/din/dout/full/empty.
  - Same clock and reset as this block; show-ahead dout.
  - Simultaneous push and pop is legal even when full or empty, and pop is processed first.

## Test plan
All scenarios use SYS_FREQ=1600, BAUD=100 (16 cycles/bit), FIFO_DEPTH=4.
- TX single byte: write 0x55 to addr 1 → o_tx shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 16 cycles; tx_idle=1 after the stop bit.
- TX full: 6 back-to-back writes 0x01..0x06 → first byte enters the shifter and four are queued, so one byte (0x06) is dropped; tx_full reads 1 while 4 are queued.
- RX and overrun: drive 5 frames 0xA0..0xA4 with no reads → STATUS = rx_avail|rx_overrun; reads return 0xA0..0xA3 then 0x00; CTRL write 0x04 clears overrun.
- Frame error: drive 0x3C with the stop bit low → no push; STATUS bit3 = 1.
- Interrupt: with ie_rx=1, receive 0x7E → o_int rises; reading DATA returns 0x7E and o_int falls.
- Break: hold i_rx low for 320 cycles → o_reset = 1 at cycle 320 + 2; it falls 2 cycles after i_rx returns high; no RX push occurs.
